// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB slave backed by word-wide memory
// Fixed wait states per OKAY transfer, two-cycle ERROR response, byte-lane writes.
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hmaster,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t        state_q;
  logic [3:0]    wait_cnt_q;
  logic          hready_q;
  logic [1:0]    hresp_q;
  logic          dp_valid_q;
  logic          dp_write_q;
  logic [AW+1:0] dp_addr_q;
  logic [1:0]    dp_size_q;

  logic [31:0]   mem [MEM_DEPTH];
  logic          accept;
  logic          xfer_err;
  logic          wr_en;
  logic [3:0]    be_d;
  logic          unused_ok;

  assign unused_ok = ^{hburst, hmastlock, hmaster, htrans[0]};

  // hready_q gates acceptance so nothing new is taken while stalling.
  assign accept   = hsel && hready_in && htrans[1] && hready_q;
  assign xfer_err = ({2'b00, haddr[31:2]} >= 32'(MEM_DEPTH)) ||
                    (hsize > 3'b010) ||
                    ((hsize == 3'b001) && haddr[0]) ||
                    ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q    <= ST_READY;
      wait_cnt_q <= 4'd0;
      hready_q   <= 1'b1;
      hresp_q    <= 2'b00;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_size_q  <= 2'b00;
    end else begin
      case (state_q)
        ST_READY, ST_ERR2: begin
          state_q    <= ST_READY;
          hready_q   <= 1'b1;
          hresp_q    <= 2'b00;
          dp_valid_q <= 1'b0;
          if (accept) begin
            dp_write_q <= hwrite;
            dp_addr_q  <= haddr[AW+1:0];
            dp_size_q  <= hsize[1:0];
            if (xfer_err) begin
              state_q  <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 2'b01;
            end else begin
              dp_valid_q <= 1'b1;
              if (WAIT_STATES > 0) begin
                state_q    <= ST_WAIT;
                hready_q   <= 1'b0;
                wait_cnt_q <= 4'(WAIT_STATES);
              end
            end
          end
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            state_q  <= ST_READY;
            hready_q <= 1'b1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 2'b01;
        end
        default: begin
          state_q  <= ST_READY;
          hready_q <= 1'b1;
          hresp_q  <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    be_d = 4'b0000;
    case (dp_size_q)
      2'd0:    be_d = 4'b0001 << dp_addr_q[1:0];
      2'd1:    be_d = dp_addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  // The data phase ends on the edge where this slave drives hready high.
  assign wr_en = dp_valid_q && dp_write_q && hready_q;

  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) mem[dp_addr_q[AW+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hready = hready_q;
  assign hresp  = hresp_q;
  assign hrdata = (dp_valid_q && !dp_write_q && hready_q) ? mem[dp_addr_q[AW+1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem
// Two instances: zero wait states and three wait states, sharing the bus inputs.
module tb_ahb_slave_mem;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  logic        hclk, hreset;
  logic        hsel0, hsel3;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hmastlock;
  logic [3:0]  hmaster;
  logic        hready0, hready3;
  logic [1:0]  hresp0, hresp3;
  logic [31:0] hrdata0, hrdata3;
  logic        use3;
  logic        hrdy_bus;
  logic [1:0]  hresp_sel;
  logic [31:0] hrdata_sel;

  assign hrdy_bus   = use3 ? hready3 : hready0;
  assign hresp_sel  = use3 ? hresp3  : hresp0;
  assign hrdata_sel = use3 ? hrdata3 : hrdata0;

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hmaster(hmaster), .hwdata(hwdata), .hready_in(hrdy_bus),
    .hready(hready0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hmaster(hmaster), .hwdata(hwdata), .hready_in(hrdy_bus),
    .hready(hready3), .hresp(hresp3), .hrdata(hrdata3)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        is_read;
    logic        err;
    logic [1:0]  resp;
    logic [31:0] data;
    int          waits;
  } sb_t;

  sb_t         sb[$];
  sb_t         cur;
  logic        dp_open;
  int          waits_seen;
  logic [1:0]  low_resp;
  logic [31:0] mdl [int];
  logic [31:0] pend_wdata;
  logic [31:0] saved;
  int          checks, errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [2:0] size);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_B:    r[8*int'(off) +: 8] = wd[8*int'(off) +: 8];
      SZ_H:    r[16*int'(off[1]) +: 16] = wd[16*int'(off[1]) +: 16];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Drive one address phase, push its expected data-phase result, wait for acceptance.
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                           input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    sb_t e;
    int  n;
    int  k;
    hwdata    = pend_wdata;
    hsel0     = sel && !use3;
    hsel3     = sel && use3;
    htrans    = trans;
    haddr     = addr;
    hwrite    = wr;
    hsize     = size;
    hburst    = 3'($urandom_range(7));
    hmastlock = 1'($urandom_range(1));
    hmaster   = 4'($urandom_range(15));
    pend_wdata = wdata;
    e.is_read = 1'b0; e.err = 1'b0; e.resp = 2'b00; e.data = 32'h0; e.waits = 0;
    if (sel && trans[1]) begin
      k = int'(addr[31:2]);
      if (k >= 256 || size > SZ_W || (size == SZ_H && addr[0]) ||
          (size == SZ_W && addr[1:0] != 2'b00)) begin
        e.err = 1'b1; e.resp = 2'b01; e.waits = 1;
      end else begin
        e.waits = use3 ? 3 : 0;
        if (wr) mdl[k] = merge(mdl.exists(k) ? mdl[k] : 32'h0, wdata, addr[1:0], size);
        else begin
          e.is_read = 1'b1;
          e.data = mdl.exists(k) ? mdl[k] : 32'h0;
        end
      end
    end
    sb.push_back(e);
    n = 0;
    @(negedge hclk);
    while (!hrdy_bus && n < 50) begin
      @(negedge hclk);
      n++;
    end
    check("accept", {31'b0, hrdy_bus}, 32'd1);
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, IDLE, 32'h0, 1'b0, SZ_W, 32'h0);
  endtask

  // Closes the open data phase when hready is high, then opens the one accepted at the next edge.
  always @(negedge hclk) begin
    if (!hreset) begin
      dp_open = 1'b0;
      sb.delete();
    end else begin
      if (dp_open) begin
        if (hrdy_bus) begin
          check("waits", 32'(waits_seen), 32'(cur.waits));
          check("resp", {30'b0, hresp_sel}, {30'b0, cur.resp});
          if (cur.waits > 0) check("low_resp", {30'b0, low_resp}, {31'b0, cur.err});
          if (cur.is_read || cur.err) check("rdata", hrdata_sel, cur.data);
          dp_open = 1'b0;
        end else begin
          if (waits_seen == 0) low_resp = hresp_sel;
          waits_seen++;
        end
      end
      if (hrdy_bus && sb.size() > 0) begin
        cur = sb.pop_front();
        dp_open = 1'b1;
        waits_seen = 0;
        low_resp = 2'b00;
      end
    end
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    dp_open = 1'b0; waits_seen = 0; low_resp = 2'b00;
    hreset = 1'b0; use3 = 1'b0; pend_wdata = 32'h0;
    hsel0 = 1'b0; hsel3 = 1'b0; haddr = 32'h0; htrans = IDLE; hwrite = 1'b0;
    hsize = SZ_W; hburst = 3'b0; hmastlock = 1'b0; hmaster = 4'h0; hwdata = 32'h0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hready0", {31'b0, hready0}, 32'd1);
    check("rst_hresp0",  {30'b0, hresp0}, 32'd0);
    check("rst_hrdata0", hrdata0, 32'h0);
    check("rst_hready3", {31'b0, hready3}, 32'd1);
    check("rst_hresp3",  {30'b0, hresp3}, 32'd0);
    check("rst_hrdata3", hrdata3, 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b1;

    // Zero-wait: back-to-back write/read, byte and halfword lanes.
    bus_cycle(1'b1, NONSEQ, 32'h10, 1'b1, SZ_W, 32'hDEADBEEF);
    bus_cycle(1'b1, NONSEQ, 32'h10, 1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h10, 1'b1, SZ_W, 32'h00000000);
    bus_cycle(1'b1, NONSEQ, 32'h11, 1'b1, SZ_B, 32'h0000AA00);
    bus_cycle(1'b1, NONSEQ, 32'h10, 1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h14, 1'b1, SZ_W, 32'hFFFFFFFF);
    bus_cycle(1'b1, SEQ,    32'h16, 1'b1, SZ_H, 32'h12340000);
    bus_cycle(1'b1, NONSEQ, 32'h14, 1'b0, SZ_W, 32'h0);
    idle_cycles(2);

    // Boundary and error transfers.
    bus_cycle(1'b1, NONSEQ, 32'h3FC, 1'b1, SZ_W, 32'hA5A5A5A5);
    bus_cycle(1'b1, NONSEQ, 32'h400, 1'b1, SZ_W, 32'h11111111);
    bus_cycle(1'b1, NONSEQ, 32'h02,  1'b1, SZ_W, 32'h22222222);
    bus_cycle(1'b1, NONSEQ, 32'h13,  1'b1, SZ_H, 32'h33333333);
    bus_cycle(1'b1, NONSEQ, 32'h14,  1'b1, 3'b011, 32'h44444444);
    bus_cycle(1'b1, NONSEQ, 32'h400, 1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h3FC, 1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h10,  1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h14,  1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h00,  1'b0, SZ_W, 32'h0);
    idle_cycles(1);

    // BUSY, deselected and IDLE cycles inside a burst.
    bus_cycle(1'b1, NONSEQ, 32'h24, 1'b1, SZ_W, 32'h55555555);
    bus_cycle(1'b1, SEQ,    32'h20, 1'b1, SZ_W, 32'h0BADF00D);
    bus_cycle(1'b1, BUSY,   32'h24, 1'b1, SZ_W, 32'hFFFFFFFF);
    bus_cycle(1'b0, NONSEQ, 32'h24, 1'b1, SZ_W, 32'hEEEEEEEE);
    bus_cycle(1'b1, IDLE,   32'h24, 1'b1, SZ_W, 32'hDDDDDDDD);
    bus_cycle(1'b1, SEQ,    32'h28, 1'b1, SZ_W, 32'h12345678);
    bus_cycle(1'b1, NONSEQ, 32'h24, 1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h20, 1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h28, 1'b0, SZ_W, 32'h0);
    idle_cycles(3);

    // Three wait states.
    use3 = 1'b1;
    idle_cycles(1);
    bus_cycle(1'b1, NONSEQ, 32'h20, 1'b1, SZ_W, 32'hCAFEF00D);
    bus_cycle(1'b1, NONSEQ, 32'h20, 1'b0, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h21, 1'b1, SZ_W, 32'h0);
    bus_cycle(1'b1, NONSEQ, 32'h30, 1'b1, SZ_W, 32'h11111111);
    idle_cycles(2);

    // Reset during the wait states of a write: the write must be dropped.
    saved = mdl[12];
    bus_cycle(1'b1, NONSEQ, 32'h30, 1'b1, SZ_W, 32'h22222222);
    hwdata = 32'h22222222;
    hsel3 = 1'b0;
    htrans = IDLE;
    @(posedge hclk);
    #2;
    hreset = 1'b0;
    #1;
    check("abort_hready", {31'b0, hready3}, 32'd1);
    check("abort_hresp",  {30'b0, hresp3}, 32'd0);
    check("abort_hrdata", hrdata3, 32'h0);
    mdl[12] = saved;
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b1;
    bus_cycle(1'b1, NONSEQ, 32'h30, 1'b0, SZ_W, 32'h0);
    idle_cycles(2);

    n = 0;
    while ((sb.size() != 0 || dp_open) && n < 100) begin
      @(posedge hclk);
      n++;
    end
    check("drain", 32'(sb.size()) + {31'b0, dp_open}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: hclk clocks all state; hreset asserted low clears it immediately.
REQ-002 Parameter MEM_DEPTH, default 256, SHALL set the number of 32-bit words of storage.
REQ-003 Parameter WAIT_STATES, default 0 (range 0-15), SHALL set the hready-low cycles inserted per OKAY transfer.
REQ-004 Port hclk, input, 1: bus clock.
REQ-005 Port hreset, input, 1: asynchronous active-low reset.
REQ-006 Port hsel, input, 1: slave selected by decoder.
REQ-007 Port haddr, input, 32: transfer byte address.
REQ-008 Port htrans, input, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 Port hwrite, input, 1: 1=write, 0=read.
REQ-010 Port hsize, input, 3: 000 byte, 001 halfword, 010 word; others illegal.
REQ-011 Port hburst, input, 3: burst type, accepted and otherwise ignored.
REQ-012 Port hmastlock, input, 1: locked transfer, ignored.
REQ-013 Port hmaster, input, 4: current master id, ignored.
REQ-014 Port hwdata, input, 32: write data, valid in data phase.
REQ-015 Port hready_in, input, 1: bus-level hready, qualifies the address phase.
REQ-016 Port hready, output, 1: this slave's transfer-done.
REQ-017 Port hresp, output, 2: 00 OKAY, 01 ERROR; 10/11 never driven.
REQ-018 Port hrdata, output, 32: read data, valid when hready=1 in a read data phase.

Function
REQ-019 An address phase SHALL be accepted on a rising hclk edge where hsel=1, hready_in=1 and htrans[1]=1; it captures haddr, hwrite and hsize.
REQ-020 IDLE/BUSY transfers, or hsel=0, SHALL produce a zero-wait OKAY response and no memory access.
REQ-021 An accepted transfer SHALL be an error if haddr[31:2] >= MEM_DEPTH, hsize > 010, halfword with haddr[0]=1, or word with haddr[1:0]!=00.
REQ-022 The FSM SHALL have the states READY, WAIT, ERR1 and ERR2.
REQ-023 READY: hready=1, hresp=00; on an accepted legal transfer go to WAIT if WAIT_STATES>0, else stay in READY; on an accepted error transfer go to ERR1.
REQ-024 WAIT: hready=0, hresp=00; a counter loaded with WAIT_STATES at acceptance decrements each cycle; return to READY after WAIT_STATES cycles.
REQ-025 ERR1: hready=0, hresp=01 for one cycle, then ERR2.
REQ-026 ERR2: hready=1, hresp=01 for one cycle, then READY (or accept a new transfer exactly as in READY).
REQ-027 A write SHALL update memory on the edge that ends the data phase (hready=1); only the byte lanes selected by hsize and haddr[1:0] are written (little-endian); an errored write changes nothing.
REQ-028 Read data SHALL be the addressed word, all 32 bits, little-endian lanes; it is presented while hready=1 in the data phase, and hrdata=0 in ERR1/ERR2.
REQ-029 Pipelining: with WAIT_STATES=0, back-to-back accepted transfers SHALL complete one per cycle.
REQ-030 Read-after-write: a read accepted in the same cycle as the preceding write's data phase SHALL return the newly written data.
REQ-031 While hready=0, a new address phase SHALL NOT be accepted.
REQ-032 Storage SHALL not be cleared by reset; its contents are undefined until written.

Reset
REQ-033 While hreset=0: FSM=READY, wait counter=0, hready=1, hresp=00, hrdata=0, captured address/control cleared.
REQ-034 Reset asserted mid-transfer SHALL abort it; a pending write SHALL not be committed.

Verification
REQ-035 WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> hready stays 1; the read data phase returns hrdata=0xDEADBEEF.
REQ-036 Byte write 0xAA to 0x11 over a word 0x00000000 -> a read of 0x10 returns 0x0000AA00.
REQ-037 WAIT_STATES=3: a read of 0x20 -> hready low exactly 3 cycles, then high with hresp=00 and the correct data.
REQ-038 Access 0x400 with MEM_DEPTH=256, or a word access to 0x02 -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01); memory is unchanged.
REQ-039 hreset low during the WAIT of a write to 0x30 -> outputs go to reset values immediately; a later read of 0x30 shows the old value.
REQ-040 An htrans=BUSY/IDLE, or hsel=0, cycle interleaved in a burst -> hready=1, hresp=00, no memory update.
